// File: rtl/mem_io_ctrl_if.sv
// CPU-side memory/I-O bus between the processor core and mem_io_ctrl.
// Ports: mem_cmd/mem_addr/write_data from the CPU; read_data/mem_ready back from the controller.
// The master modport is the CPU side. The slave modport is the controller side.
interface mem_io_ctrl_if;
  logic [1:0]  mem_cmd;     // 00 NONE, 01 READ, 10 WRITE, 11 reserved
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;

  modport master (output mem_cmd, mem_addr, write_data, input read_data, mem_ready);
  modport slave  (input mem_cmd, mem_addr, write_data, output read_data, mem_ready);
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/I-O bus controller: decodes CPU accesses to the 256x16 RAM, the LED register or the switch port.
// Latency: a RAM read takes 3 edges from command to ready; every other access takes 2 edges.
// Backpressure: the CPU holds its command until the one-cycle mem_ready pulse; a command present in DONE is ignored.
// Ports: clk, reset_n (async active-low), bus (slave side), RAM port (ram_addr/ram_write/ram_din/ram_dout),
//        sw_in (async switches), halt_in, and ledr ([7:0] LED reg, [8] halt latch, [9] bus error latch).
module mem_io_ctrl #(
  parameter int          RAM_AW   = 8,
  parameter logic [8:0]  LED_ADDR = 9'h100,
  parameter logic [8:0]  SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_io_ctrl_if.slave      bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,
  input  logic [7:0]        sw_in,
  input  logic              halt_in,
  output logic [9:0]        ledr
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_RAM = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_read_data;
  logic [7:0]  r_led;
  logic        r_halt;
  logic        r_err;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic w_is_ram, w_is_led, w_is_sw;
  logic w_rd, w_wr;
  logic w_mem_ready;

  // Address decode and command qualification; they are only acted on in IDLE.
  assign w_is_ram = ~bus.mem_addr[8];
  assign w_is_led = (bus.mem_addr == LED_ADDR);
  assign w_is_sw  = (bus.mem_addr == SW_ADDR);
  assign w_rd     = (r_state == IDLE) && (bus.mem_cmd == CMD_READ);
  assign w_wr     = (r_state == IDLE) && (bus.mem_cmd == CMD_WRITE);

  // The RAM address and data follow the CPU bus directly.
  assign ram_addr = bus.mem_addr[RAM_AW-1:0];
  assign ram_din  = bus.write_data;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd && w_is_ram) w_next = RD_RAM;
        else if (w_rd || w_wr) w_next = DONE;
      end
      RD_RAM:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs. A RAM write strobes for the single IDLE cycle of the access only.
  always_comb begin
    ram_write   = 1'b0;
    w_mem_ready = 1'b0;
    case (r_state)
      IDLE:    ram_write   = w_wr && w_is_ram;
      DONE:    w_mem_ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath: read return, LED register, sticky latches, and the switch synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_data <= '0;
      r_led       <= '0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (halt_in) r_halt <= 1'b1;

      if (r_state == RD_RAM) r_read_data <= ram_dout;

      if (w_rd && !w_is_ram) begin
        if (w_is_led)     r_read_data <= {8'h00, r_led};
        else if (w_is_sw) r_read_data <= {8'h00, r_sw_sync};
        else begin
          r_read_data <= '0;
          r_err       <= 1'b1;
        end
      end

      // The switch port is read-only, so a write to it counts as a bus error like an unmapped write.
      if (w_wr && !w_is_ram) begin
        if (w_is_led) r_led <= bus.write_data[7:0];
        else          r_err <= 1'b1;
      end
    end
  end

  assign bus.read_data = r_read_data;
  assign bus.mem_ready = w_mem_ready;
  assign ledr          = {r_err, r_halt, r_led};

endmodule
